axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-Lite memory-mapped register-file slave that sits downstream of the bus crossbar.
//  It terminates one crossbar master port (m1 or m2) and provides NUM_REGS read/write
//  registers with byte-lane write strobes, OKAY/SLVERR responses, and a flat register
//  output for fabric logic. Independent write and read FSMs; one outstanding transaction per direction.
// PARAMETERS
//  DATA_WIDTH  32     data bus width (multiple of 8)
//  ADDR_WIDTH  8      address width
//  RESP_WIDTH  3      response field width (OKAY=0, SLVERR=2)
//  NUM_REGS    4      number of 32-bit word registers (>=1)
//  BASE_ADDR   8'h00  byte address of register 0 (m1 window 0x00; m2 instance uses 0x10)
// PORTS
//  s0_axi_aclk     in   1                 clock, all logic on rising edge
//  s0_axi_aresetn  in   1                 asynchronous active-low reset
//  s0_axi_awaddr   in   ADDR_WIDTH        write address
//  s0_axi_awvalid  in   1                 write address valid
//  s0_axi_awready  out  1                 write address ready
//  s0_axi_wdata    in   DATA_WIDTH        write data
//  s0_axi_wstrb    in   DATA_WIDTH/8+1    byte strobes; bit [DATA_WIDTH/8] is ignored
//  s0_axi_wvalid   in   1                 write data valid
//  s0_axi_wready   out  1                 write data ready
//  s0_axi_bresp    out  RESP_WIDTH        write response
//  s0_axi_bvalid   out  1                 write response valid
//  s0_axi_bready   in   1                 write response ready
//  s0_axi_araddr   in   ADDR_WIDTH        read address
//  s0_axi_arvalid  in   1                 read address valid
//  s0_axi_arready  out  1                 read address ready
//  s0_axi_rdata    out  DATA_WIDTH        read data
//  s0_axi_rresp    out  RESP_WIDTH        read response
//  s0_axi_rvalid   out  1                 read data valid
//  s0_axi_rready   in   1                 read data ready
//  regs_out        out  NUM_REGS*DATA_WIDTH  register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (async, aresetn=0): all registers=0. awready=wready=arready=1. bvalid=rvalid=0.
//   bresp=rresp=0, rdata=0. Both FSMs go to IDLE. In-flight transactions are dropped.
//  Decode: in range if BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS; idx=(addr-BASE_ADDR)>>2.
//   addr[1:0] is ignored.
//  Write FSM states: W_IDLE, W_RESP.
//   - W_IDLE: awready=!aw_held and wready=!w_held. AW and W handshakes are latched independently, in either order.
//   - The commit edge is the edge on which both are held, or become held.
//     On that edge, in range: reg[idx] byte b <= wdata byte b where wstrb[b]=1; bresp<=0.
//     Out of range: no register change; bresp<=2.
//   - At commit: bvalid<=1, awready=wready<=0, go to W_RESP.
//   - W_RESP: hold bvalid/bresp until bready&&bvalid, then bvalid<=0, clear held flags, awready=wready<=1, go to W_IDLE.
//   - Best case is 2 cycles per write (AW+W on edge k, bready on edge k+1).
//  Read FSM states: R_IDLE, R_DATA.
//   - R_IDLE: arready=1. On arvalid&&arready, in range: rdata<=reg[idx], rresp<=0.
//     Out of range: rdata<=0, rresp<=2. Also rvalid<=1, arready<=0, go to R_DATA.
//   - R_DATA: rdata/rresp stay stable until rready&&rvalid, then rvalid<=0, arready<=1, go to R_IDLE.
//  Simultaneous write commit and AR handshake to the same register on the same edge:
//   rdata returns the pre-write value. The write is still applied.
//  Read and write FSMs are fully independent and never stall each other.
//  regs_out is registered, updated on the commit edge, visible the cycle after.
//  Valid outputs never drop without a handshake, except on reset.
// TESTING
//  1 Reset: hold aresetn=0 5 cycles -> regs_out=0, awready=wready=arready=1, bvalid=rvalid=0.
//  2 AW+W same cycle: addr 0x04, data 0x0000001E, strb 0xF; bready=1
//    -> bvalid 1 cycle, bresp=0, reg1=0x1E. Then read 0x04 -> rdata=0x1E, rresp=0.
//  3 W two cycles before AW: addr 0x08, data 0xAABBCCDD, strb 0x5 over reg2=0x11223344
//    -> no commit until AW arrives; reg2=0x11BB33DD; bvalid the cycle after AW.
//  4 Out-of-range write to 0x14, then read of 0x20 -> bresp=2 with no register changed;
//    rdata=0, rresp=2.
//  5 Backpressure: bready=0 / rready=0 for 4 cycles -> bvalid/rvalid, bresp/rdata stable;
//    awready/wready/arready=0 until the handshake completes.
//  6 Same-edge write 0x25 to 0x00 (reg0=0x17) and read of 0x00 -> rdata=0x17, reg0=0x25 afterwards.
//    Drop aresetn while bvalid=1 -> bvalid=0 immediately.

Source files
------------

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register-file slave: NUM_REGS word registers with byte strobes,
// independent write (AW/W -> B) and read (AR -> R) state machines.
module axi_lite_reg_slave #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           RESP_WIDTH = 3,
  parameter int unsigned           NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           s0_axi_aclk,
  input  logic                           s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_awaddr,
  input  logic                           s0_axi_awvalid,
  output logic                           s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s0_axi_wdata,
  input  logic [DATA_WIDTH/8:0]          s0_axi_wstrb,
  input  logic                           s0_axi_wvalid,
  output logic                           s0_axi_wready,
  output logic [RESP_WIDTH-1:0]          s0_axi_bresp,
  output logic                           s0_axi_bvalid,
  input  logic                           s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s0_axi_araddr,
  input  logic                           s0_axi_arvalid,
  output logic                           s0_axi_arready,
  output logic [DATA_WIDTH-1:0]          s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s0_axi_rresp,
  output logic                           s0_axi_rvalid,
  input  logic                           s0_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int unsigned STRB_W       = DATA_WIDTH / 8;
  localparam int unsigned REGION_BYTES = 4 * NUM_REGS;

  localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
  localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  // Address decode helpers; addr[1:0] drops out through the word shift.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] off;
    off = 32'(a) - 32'(BASE_ADDR);
    return (a >= BASE_ADDR) && (off < REGION_BYTES);
  endfunction

  function automatic logic [31:0] addr_word_idx(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) - 32'(BASE_ADDR)) >> 2;
  endfunction

  // Register file and write-channel state
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  w_state_e                w_state_q, w_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;

  // Read-channel state
  r_state_e                r_state_q, r_state_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;

  logic                    aw_hs, w_hs, ar_hs;
  logic [ADDR_WIDTH-1:0]   w_addr_eff;
  logic [DATA_WIDTH-1:0]   w_data_eff;
  logic [STRB_W-1:0]       w_strb_eff;
  logic [31:0]             w_idx, r_idx;
  logic                    unused_wstrb_msb;

  // The extra strobe bit carries no byte lane
  assign unused_wstrb_msb = s0_axi_wstrb[STRB_W];

  assign aw_hs = s0_axi_awvalid && awready_q;
  assign w_hs  = s0_axi_wvalid && wready_q;
  assign ar_hs = s0_axi_arvalid && arready_q;

  // A channel captured on this edge is used directly, otherwise the held copy
  assign w_addr_eff = aw_held_q ? awaddr_q : s0_axi_awaddr;
  assign w_data_eff = w_held_q ? wdata_q : s0_axi_wdata;
  assign w_strb_eff = w_held_q ? wstrb_q : s0_axi_wstrb[STRB_W-1:0];
  assign w_idx      = addr_word_idx(w_addr_eff);
  assign r_idx      = addr_word_idx(s0_axi_araddr);

  // Write FSM: latch AW and W in any order, commit once both are present
  always_comb begin : write_next
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s0_axi_awaddr;
          awready_d = 1'b0;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s0_axi_wdata;
          wstrb_d  = s0_axi_wstrb[STRB_W-1:0];
          wready_d = 1'b0;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          if (addr_in_range(w_addr_eff)) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (w_idx == i) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (w_strb_eff[b]) begin
                    regs_d[i][b*8 +: 8] = w_data_eff[b*8 +: 8];
                  end
                end
              end
            end
            bresp_d = RESP_OKAY;
          end else begin
            bresp_d = RESP_SLVERR;
          end
          bvalid_d  = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s0_axi_bready && bvalid_q) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read FSM: sample the register file on the AR edge (pre-write value on collision)
  always_comb begin : read_next
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rdata_d = '0;
          if (addr_in_range(s0_axi_araddr)) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (r_idx == i) begin
                rdata_d = regs_q[i];
              end
            end
            rresp_d = RESP_OKAY;
          end else begin
            rresp_d = RESP_SLVERR;
          end
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s0_axi_rready && rvalid_q) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write-side state registers and register file
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      regs_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      regs_q    <= regs_d;
    end
  end

  // Read-side state registers
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s0_axi_awready = awready_q;
  assign s0_axi_wready  = wready_q;
  assign s0_axi_bvalid  = bvalid_q;
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_arready = arready_q;
  assign s0_axi_rvalid  = rvalid_q;
  assign s0_axi_rdata   = rdata_q;
  assign s0_axi_rresp   = rresp_q;
  assign regs_out       = regs_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: a vector table of single transactions
// followed by hand-written multi-cycle sequences.
module tb_axi_lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [4:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [2:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [2:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] regs_out;

  always #5 clk = ~clk;

  axi_lite_reg_slave dut (
    .s0_axi_aclk    (clk),
    .s0_axi_aresetn (rst_n),
    .s0_axi_awaddr  (awaddr),
    .s0_axi_awvalid (awvalid),
    .s0_axi_awready (awready),
    .s0_axi_wdata   (wdata),
    .s0_axi_wstrb   (wstrb),
    .s0_axi_wvalid  (wvalid),
    .s0_axi_wready  (wready),
    .s0_axi_bresp   (bresp),
    .s0_axi_bvalid  (bvalid),
    .s0_axi_bready  (bready),
    .s0_axi_araddr  (araddr),
    .s0_axi_arvalid (arvalid),
    .s0_axi_arready (arready),
    .s0_axi_rdata   (rdata),
    .s0_axi_rresp   (rresp),
    .s0_axi_rvalid  (rvalid),
    .s0_axi_rready  (rready),
    .regs_out       (regs_out)
  );

  typedef struct {
    bit           is_wr;
    logic [7:0]   addr;
    logic [31:0]  data;
    logic [4:0]   strb;
    logic [2:0]   exp_resp;
    logic [31:0]  exp_rdata;
    logic [127:0] exp_regs;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together, bready held high
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                          output logic [2:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    check("wr_bvalid_seen", 128'(bvalid), 128'(1));
    resp = bresp;
    tick();
    check("wr_bvalid_drop", 128'(bvalid), 128'(0));
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] resp);
    int n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    check("rd_rvalid_seen", 128'(rvalid), 128'(1));
    d = rdata;
    resp = rresp;
    tick();
    check("rd_rvalid_drop", 128'(rvalid), 128'(0));
  endtask

  initial begin
    logic [2:0]  resp;
    logic [31:0] data;

    vecs[0] = '{1'b1, 8'h04, 32'h0000001E, 5'h0F, 3'd0, 32'h0,
                128'h00000000_00000000_0000001E_00000000};
    vecs[1] = '{1'b0, 8'h04, 32'h0,        5'h00, 3'd0, 32'h0000001E,
                128'h00000000_00000000_0000001E_00000000};
    vecs[2] = '{1'b1, 8'h08, 32'h11223344, 5'h0F, 3'd0, 32'h0,
                128'h00000000_11223344_0000001E_00000000};
    vecs[3] = '{1'b1, 8'h00, 32'h00000017, 5'h0F, 3'd0, 32'h0,
                128'h00000000_11223344_0000001E_00000017};
    vecs[4] = '{1'b1, 8'h0C, 32'hDEADBEEF, 5'h13, 3'd0, 32'h0,
                128'h0000BEEF_11223344_0000001E_00000017};
    vecs[5] = '{1'b0, 8'h0F, 32'h0,        5'h00, 3'd0, 32'h0000BEEF,
                128'h0000BEEF_11223344_0000001E_00000017};
    vecs[6] = '{1'b1, 8'h14, 32'hFFFFFFFF, 5'h0F, 3'd2, 32'h0,
                128'h0000BEEF_11223344_0000001E_00000017};
    vecs[7] = '{1'b0, 8'h20, 32'h0,        5'h00, 3'd2, 32'h0,
                128'h0000BEEF_11223344_0000001E_00000017};
    vecs[8] = '{1'b0, 8'h10, 32'h0,        5'h00, 3'd2, 32'h0,
                128'h0000BEEF_11223344_0000001E_00000017};
    vecs[9] = '{1'b0, 8'h08, 32'h0,        5'h00, 3'd0, 32'h11223344,
                128'h0000BEEF_11223344_0000001E_00000017};

    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (5) tick();

    check("rst_regs_out", regs_out, 128'h0);
    check("rst_awready", 128'(awready), 128'(1));
    check("rst_wready", 128'(wready), 128'(1));
    check("rst_arready", 128'(arready), 128'(1));
    check("rst_bvalid", 128'(bvalid), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_rdata", 128'(rdata), 128'h0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < NV; k++) begin
      if (vecs[k].is_wr) begin
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, resp);
        check($sformatf("v%0d_bresp", k), 128'(resp), 128'(vecs[k].exp_resp));
      end else begin
        do_read(vecs[k].addr, data, resp);
        check($sformatf("v%0d_rdata", k), 128'(data), 128'(vecs[k].exp_rdata));
        check($sformatf("v%0d_rresp", k), 128'(resp), 128'(vecs[k].exp_resp));
      end
      check($sformatf("v%0d_regs", k), regs_out, vecs[k].exp_regs);
    end

    // W two cycles ahead of AW, then B held off for four cycles
    bready = 1'b0;
    wdata = 32'hAABBCCDD; wstrb = 5'h05; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("wfirst_c%0d_bvalid", c), 128'(bvalid), 128'(0));
      check($sformatf("wfirst_c%0d_wready", c), 128'(wready), 128'(0));
      check($sformatf("wfirst_c%0d_awready", c), 128'(awready), 128'(1));
      check($sformatf("wfirst_c%0d_regs", c), regs_out,
            128'h0000BEEF_11223344_0000001E_00000017);
      if (c == 0) tick();
    end
    awaddr = 8'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_bvalid", 128'(bvalid), 128'(1));
    check("wfirst_bresp", 128'(bresp), 128'(0));
    check("wfirst_reg2", regs_out, 128'h0000BEEF_11BB33DD_0000001E_00000017);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("bp_c%0d_bvalid", c), 128'(bvalid), 128'(1));
      check($sformatf("bp_c%0d_bresp", c), 128'(bresp), 128'(0));
      check($sformatf("bp_c%0d_awready", c), 128'(awready), 128'(0));
      check($sformatf("bp_c%0d_wready", c), 128'(wready), 128'(0));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bp_bvalid_drop", 128'(bvalid), 128'(0));
    check("bp_awready_back", 128'(awready), 128'(1));
    check("bp_wready_back", 128'(wready), 128'(1));

    // Read with rready held low for four cycles
    rready = 1'b0;
    araddr = 8'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rbp_c%0d_rvalid", c), 128'(rvalid), 128'(1));
      check($sformatf("rbp_c%0d_rdata", c), 128'(rdata), 128'h11BB33DD);
      check($sformatf("rbp_c%0d_arready", c), 128'(arready), 128'(0));
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rbp_rvalid_drop", 128'(rvalid), 128'(0));
    check("rbp_arready_back", 128'(arready), 128'(1));

    // Same-edge write and read of reg0: read returns the old value
    awaddr = 8'h00; wdata = 32'h00000025; wstrb = 5'h0F;
    araddr = 8'h00;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("coll_rvalid", 128'(rvalid), 128'(1));
    check("coll_rdata", 128'(rdata), 128'h00000017);
    check("coll_rresp", 128'(rresp), 128'(0));
    check("coll_bvalid", 128'(bvalid), 128'(1));
    check("coll_reg0", regs_out, 128'h0000BEEF_11BB33DD_0000001E_00000025);

    // Reset asserted mid-response clears everything without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bvalid", 128'(bvalid), 128'(0));
    check("arst_rvalid", 128'(rvalid), 128'(0));
    check("arst_regs", regs_out, 128'h0);
    check("arst_awready", 128'(awready), 128'(1));
    check("arst_arready", 128'(arready), 128'(1));
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
